mealy_pattern_detector: RTL and testbench
=========================================

# mealy_pattern_detector

Parametrised Mealy-type serial pattern detector that succeeds the fixed zero-run detector. It watches a 1-bit serial stream and asserts `y_out` combinationally in the same cycle as the bit that completes a programmable `PATTERN_W`-bit pattern. It adds an input-valid qualifier, selectable overlapping or non-overlapping detection, and a saturating match counter. It sits directly on a serial input line in the sequential-circuits lab set and drives a single-bit detect flag plus a status count.

## Interface
Parameters:
- `PATTERN_W`, 3: pattern length in bits; legal range 2..16.
- `PATTERN`, 3'b000: target pattern. MSB is the oldest bit, LSB is the most recent bit.
- `CNT_W`, 8: width of `match_count`.

Ports:
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `x_valid`  input  1  qualifies `x_in`; when low, the bit is ignored and state holds.
- `x_in`  input  1  serial data bit.
- `overlap_en`  input  1  1 = overlapping detection, 0 = non-overlapping.
- `count_clr`  input  1  synchronous clear of `match_count`.
- `y_out`  output  1  Mealy detect flag.
- `match_count`  output  CNT_W  saturating count of detections; present only with `MEALY_DET_COUNT_EN`.

## Operation
- State registers:
  - `hist[PATTERN_W-2:0]`: the last PATTERN_W-1 accepted bits, newest in the LSB.
  - `fill`: the number of accepted bits since the last reset or flush, saturating at PATTERN_W-1.
- Combinational Mealy output:
  - `y_out = reset & x_valid & (fill == PATTERN_W-1) & ({hist, x_in} == PATTERN)`.
- On each rising edge:
  - `reset` low: `hist` <= 0, `fill` <= 0, `match_count` <= 0. Other inputs are ignored.
  - `x_valid` low: no state change.
  - `x_valid` high and `y_out` high and `overlap_en` = 0: flush. `fill` <= 0 and `hist` <= 0. The matched bits cannot contribute to the next match.
  - Otherwise with `x_valid` high: `hist` <= {hist[PATTERN_W-3:0], x_in}. For PATTERN_W = 2, `hist` <= x_in. `fill` <= min(fill+1, PATTERN_W-1).
- Overlap mode keeps shifting after a match. A run of k zeros with the default pattern yields k-2 detections.
- Counter behaviour:
  - `count_clr` high sets `match_count` to 0. This has priority over increment.
  - Else, when `y_out` is high, `match_count` increments.
  - The counter saturates at 2^CNT_W-1 and never wraps.

## Timing
- Detection latency is zero cycles. `y_out` rises in the same cycle that the completing `x_in` is presented with `x_valid`.
- `x_in`, `x_valid` and `overlap_en` must be stable before the rising edge.
- Reset values:
  - `y_out` = 0. It is held 0 while `reset` is low, independent of state.
  - `match_count` = 0.
- After reset or a flush, the first possible detection is on the PATTERN_W-th valid bit.
- Reset mid-pattern discards all history; a partial match never completes across reset.
- Gaps in `x_valid` are transparent: history spans invalid cycles. `y_out` is 0 during any gap cycle.
- An `overlap_en` change takes effect for the match evaluated in the same cycle, because the flush decision uses the current value.
- `count_clr` and `y_out` high together: the count becomes 0, not 1.

## Configuration
- `MEALY_DET_COUNT_EN` defined: the `match_count` port, the counter register and `count_clr` are compiled in.
- `MEALY_DET_COUNT_EN` undefined:
  - `match_count` and `count_clr` are absent from the port list.
  - No counter logic is built.
  - Detection behaviour is identical to the defined case.

## Test plan
1. Defaults, `overlap_en`=1, `x_valid`=1, stream 1,0,0,0,0,0,1 -> `y_out` high on the 4th, 5th and 6th bits; `match_count`=3.
2. Same stream with `overlap_en`=0 -> `y_out` high on the 4th bit only. The 5th and 6th bits refill the history, so there is no second match. `match_count`=1.
3. Defaults, bits 0,0 then `x_valid` low for 3 cycles, then 0 -> no `y_out` during the gap; `y_out` high on the final valid 0.
4. Defaults, bits 0,0, `reset` low for one edge, then 0 -> `y_out` stays 0. Two further zeros are needed; `y_out` is high on the 3rd post-reset zero.
5. `PATTERN_W`=4, `PATTERN`=4'b1011, `overlap_en`=1, stream 1,0,1,1,0,1,1 -> `y_out` high on the 4th and 7th bits.
6. `CNT_W`=2, overlap, 10 consecutive zeros -> `match_count` saturates at 3. Then assert `count_clr` on a detecting cycle -> `match_count`=0.

Source files
------------

// File: rtl/mealy_pattern_detector.sv
// -----------------------------------------------------------------------------
// mealy_pattern_detector
//
// Mealy-type serial pattern detector. The detector keeps the last PATTERN_W-1
// accepted bits and flags y_out combinationally in the same cycle as the bit
// that completes PATTERN. Bits are accepted only while x_valid is high. Gaps in
// x_valid do not disturb the history.
//
// Overlapping detection (overlap_en = 1) keeps shifting after a match.
// Non-overlapping detection (overlap_en = 0) flushes the history on a match, so
// the matched bits cannot be reused.
//
// Optional feature macro: MEALY_DET_COUNT_EN
//   When defined, this adds count_clr and match_count, a saturating count of
//   detections.
//
// Parameters:
//   PATTERN_W  pattern length in bits (2..16)
//   PATTERN    target pattern; MSB is the oldest bit, LSB the newest
//   CNT_W      width of match_count
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   x_valid      qualifies x_in; when low the bit is ignored and state holds
//   x_in         serial data bit
//   overlap_en   1 = overlapping detection, 0 = non-overlapping
//   count_clr    synchronous clear of match_count (MEALY_DET_COUNT_EN only)
//   match_count  saturating detection count     (MEALY_DET_COUNT_EN only)
//   y_out        Mealy detect flag
// -----------------------------------------------------------------------------
module mealy_pattern_detector #(
  parameter int unsigned          PATTERN_W = 3,
  parameter logic [PATTERN_W-1:0] PATTERN   = 3'b000,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic             x_in,
  input  logic             overlap_en,
`ifdef MEALY_DET_COUNT_EN
  input  logic             count_clr,
  output logic [CNT_W-1:0] match_count,
`endif
  output logic             y_out
);

  // The fill counter only has to reach PATTERN_W-1 (at most 15).
  localparam int unsigned          FILL_W   = $clog2(PATTERN_W);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PATTERN_W - 1);
  localparam logic [FILL_W-1:0]    FILL_ONE = FILL_W'(1);

  logic [PATTERN_W-2:0] hist_r;
  logic [PATTERN_W-2:0] hist_nx_s;
  logic [FILL_W-1:0]    fill_r;
  logic [FILL_W-1:0]    fill_nx_s;
  logic [PATTERN_W-1:0] window_s;
  logic                 y_s;

  // Candidate pattern: the stored history with the current bit appended.
  // Its low PATTERN_W-1 bits are the shifted history for every legal width,
  // including PATTERN_W = 2.
  assign window_s = {hist_r, x_in};

  // Mealy detect: needs a full history, a qualified bit and reset released.
  always_comb begin
    y_s = 1'b0;
    if (reset && x_valid && (fill_r == FILL_MAX) && (window_s == PATTERN)) begin
      y_s = 1'b1;
    end else begin
      y_s = 1'b0;
    end
  end

  assign y_out = y_s;

  // Next history/fill: hold on gaps, flush on a non-overlapping match, shift otherwise.
  always_comb begin
    hist_nx_s = hist_r;
    fill_nx_s = fill_r;
    if (!x_valid) begin
      hist_nx_s = hist_r;
      fill_nx_s = fill_r;
    end else if (y_s && !overlap_en) begin
      hist_nx_s = '0;
      fill_nx_s = '0;
    end else begin
      hist_nx_s = window_s[PATTERN_W-2:0];
      if (fill_r == FILL_MAX) begin
        fill_nx_s = fill_r;
      end else begin
        fill_nx_s = fill_r + FILL_ONE;
      end
    end
  end

  // History and fill registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_r <= '0;
      fill_r <= '0;
    end else begin
      hist_r <= hist_nx_s;
      fill_r <= fill_nx_s;
    end
  end

`ifdef MEALY_DET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;

  // Counter next value: a clear beats an increment, and the count saturates.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (count_clr) begin
      cnt_nx_s = '0;
    end else if (y_s && (cnt_r != CNT_MAX)) begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Match counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nx_s;
    end
  end

  assign match_count = cnt_r;
`endif

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_mealy_pattern_detector
//
// Self-checking bench for mealy_pattern_detector. The default detector (3-bit
// all-zero pattern) is driven from a table of hand-computed vectors. Separate
// instances cover a 4-bit pattern and a narrow saturating counter. Count
// checks are compiled only when MEALY_DET_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mealy_pattern_detector;

  typedef struct {
    logic       rst;
    logic       vld;
    logic       x;
    logic       ov;
    logic       clr;
    logic       y;    // expected y_out before the edge
    logic [7:0] cnt;  // expected match_count before the edge
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default instance: PATTERN_W=3, PATTERN=3'b000.
  logic rst0 = 1'b0, vld0 = 1'b0, x0 = 1'b0, ov0 = 1'b1;
  logic y0;
`ifdef MEALY_DET_COUNT_EN
  logic       clr0 = 1'b0;
  logic [7:0] cnt0;
`endif

  mealy_pattern_detector dut0 (
    .clock      (clock),
    .reset      (rst0),
    .x_valid    (vld0),
    .x_in       (x0),
    .overlap_en (ov0),
`ifdef MEALY_DET_COUNT_EN
    .count_clr  (clr0),
    .match_count(cnt0),
`endif
    .y_out      (y0)
  );

  // Four-bit pattern instance.
  logic rst1 = 1'b0, vld1 = 1'b0, x1 = 1'b0;
  logic y1;
`ifdef MEALY_DET_COUNT_EN
  logic       clr1 = 1'b0;
  logic [7:0] cnt1;
`endif

  mealy_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011)) dut1 (
    .clock      (clock),
    .reset      (rst1),
    .x_valid    (vld1),
    .x_in       (x1),
    .overlap_en (1'b1),
`ifdef MEALY_DET_COUNT_EN
    .count_clr  (clr1),
    .match_count(cnt1),
`endif
    .y_out      (y1)
  );

`ifdef MEALY_DET_COUNT_EN
  // Two-bit counter instance for saturation.
  logic       rst2 = 1'b0, x2 = 1'b0, clr2 = 1'b0;
  logic       y2;
  logic [1:0] cnt2;

  mealy_pattern_detector #(.CNT_W(2)) dut2 (
    .clock      (clock),
    .reset      (rst2),
    .x_valid    (1'b1),
    .x_in       (x2),
    .overlap_en (1'b1),
    .count_clr  (clr2),
    .match_count(cnt2),
    .y_out      (y2)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic x, input logic o,
                     input logic c, input logic y, input logic [7:0] cn);
    vec_t e;
    e.rst = r; e.vld = v; e.x = x; e.ov = o; e.clr = c; e.y = y; e.cnt = cn;
    tbl.push_back(e);
  endtask

  initial begin
    logic [6:0] s5;
    logic [6:0] e5;

    //   rst  vld  x    ov   clr  y    cnt
    // Overlapping, stream 1,0,0,0,0,0,1.
    add(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'd1);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'd2);
    add(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,8'd3);
    add(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'd3);
    // Non-overlapping, same stream: only the 4th bit detects.
    add(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'd0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd1);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd1);
    add(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'd1);
    add(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'd1);
    // Gap in x_valid: 0,0, three invalid cycles, 0.
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'd0);
    add(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'd1);
    // Reset mid-pattern discards history.
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'd1);
    // Clear wins over increment on a detecting cycle.
    add(1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'd2);
    add(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,8'd0);
    // overlap_en dropped: the flush decision uses the current value.
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'd0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd1);

    // Initial reset of all instances for two edges.
    repeat (2) @(negedge clock);
    @(negedge clock);
    check("reset_y0", {31'd0, y0}, 32'd0);
`ifdef MEALY_DET_COUNT_EN
    check("reset_cnt0", {24'd0, cnt0}, 32'd0);
`endif

    foreach (tbl[i]) begin
      @(negedge clock);
      rst0 = tbl[i].rst; vld0 = tbl[i].vld; x0 = tbl[i].x; ov0 = tbl[i].ov;
`ifdef MEALY_DET_COUNT_EN
      clr0 = tbl[i].clr;
`endif
      #1;
      check($sformatf("row%0d_y", i), {31'd0, y0}, {31'd0, tbl[i].y});
`ifdef MEALY_DET_COUNT_EN
      check($sformatf("row%0d_cnt", i), {24'd0, cnt0}, {24'd0, tbl[i].cnt});
`endif
    end
`ifdef MEALY_DET_COUNT_EN
    @(negedge clock);
    check("final_cnt0", {24'd0, cnt0}, 32'd1);
`endif

    // Four-bit pattern 1011, overlapping, stream 1,0,1,1,0,1,1.
    s5 = 7'b1011011;
    e5 = 7'b0001001;
    @(negedge clock);
    rst1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      vld1 = 1'b1;
      x1   = s5[6-k];
      #1;
      check($sformatf("w4_bit%0d_y", k + 1), {31'd0, y1}, {31'd0, e5[6-k]});
    end

`ifdef MEALY_DET_COUNT_EN
    // Two-bit counter: ten zeros saturate at 3, then clear on a detecting cycle.
    @(negedge clock);
    rst2 = 1'b1;
    x2   = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    check("sat_cnt2", {30'd0, cnt2}, 32'd3);
    check("sat_y2", {31'd0, y2}, 32'd1);
    clr2 = 1'b1;
    @(negedge clock);
    clr2 = 1'b0;
    #1;
    check("clr_cnt2", {30'd0, cnt2}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
